// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, stall and forwarding controller for the 5-stage MIPS pipeline.
// Multi-cycle load-use stalls, ID-stage branch forwarding, memory-wait freeze and perf counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_use_rs,
  input  logic             ifid_use_rt,
  input  logic             is_branch,
  input  logic             branch_taken,
  input  logic [REG_W-1:0] idex_rs,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] idex_rd,
  input  logic             idex_regwrite,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] exmem_rd,
  input  logic             exmem_regwrite,
  input  logic             exmem_memread,
  input  logic [REG_W-1:0] memwb_rd,
  input  logic             memwb_regwrite,
  input  logic             mem_busy,
  input  logic             clr_cnt,
  output logic             pc_write,
  output logic             ifid_load,
  output logic             pipe_hold,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             fwd_br_a,
  output logic             fwd_br_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned CNT_LAT_W = 4;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_LSTALL = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [CNT_LAT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;

  logic dep_idex_rd;
  logic dep_exmem_rd;
  logic load_use;
  logic br_hazard;

  // Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic reg_match(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  function automatic logic [1:0] alu_fwd(input logic [REG_W-1:0] src);
    if (exmem_regwrite && !exmem_memread && reg_match(exmem_rd, src)) return 2'b10;
    if (memwb_regwrite && reg_match(memwb_rd, src))                   return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    dep_idex_rd  = (ifid_use_rs && reg_match(ifid_rs, idex_rd)) ||
                   (ifid_use_rt && reg_match(ifid_rt, idex_rd));
    dep_exmem_rd = (ifid_use_rs && reg_match(ifid_rs, exmem_rd)) ||
                   (ifid_use_rt && reg_match(ifid_rt, exmem_rd));
    load_use     = idex_memread && dep_idex_rd;
    br_hazard    = is_branch && ((idex_regwrite && dep_idex_rd) ||
                                 (exmem_memread && dep_exmem_rd));
  end

  // Next state and control outputs; reset forces the frozen/bubble-free output set.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    pc_write   = 1'b1;
    ifid_load  = 1'b1;
    pipe_hold  = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    forward_a  = alu_fwd(idex_rs);
    forward_b  = alu_fwd(idex_rt);
    fwd_br_a   = is_branch && exmem_regwrite && !exmem_memread && reg_match(exmem_rd, ifid_rs);
    fwd_br_b   = is_branch && exmem_regwrite && !exmem_memread && reg_match(exmem_rd, ifid_rt);

    case (state_q)
      ST_RUN: begin
        if (mem_busy) begin
          pc_write  = 1'b0;
          ifid_load = 1'b0;
          pipe_hold = 1'b1;
        end else if (load_use) begin
          pc_write   = 1'b0;
          ifid_load  = 1'b0;
          idex_flush = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = ST_LSTALL;
            count_d = CNT_LAT_W'(LOAD_LAT - 1);
          end
        end else if (br_hazard) begin
          pc_write   = 1'b0;
          ifid_load  = 1'b0;
          idex_flush = 1'b1;
        end else if (branch_taken) begin
          ifid_flush = 1'b1;
        end
      end
      default: begin
        pc_write  = 1'b0;
        ifid_load = 1'b0;
        if (mem_busy) begin
          pipe_hold = 1'b1;
        end else begin
          idex_flush = 1'b1;
          count_d    = count_q - CNT_LAT_W'(1);
          if (count_q == CNT_LAT_W'(1)) state_d = ST_RUN;
        end
      end
    endcase

    if (!rst) begin
      pc_write   = 1'b0;
      ifid_load  = 1'b0;
      pipe_hold  = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      forward_a  = 2'b00;
      forward_b  = 2'b00;
      fwd_br_a   = 1'b0;
      fwd_br_b   = 1'b0;
    end
  end

  // Saturating performance counters; clear beats increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (clr_cnt) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (!pc_write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if ((ifid_flush || idex_flush) && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      count_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a LOAD_LAT=3 instance with wide counters and a
// twin with 4-bit counters sharing the same stimulus to exercise saturation.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned REG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] ifid_rs, ifid_rt, idex_rs, idex_rt, idex_rd, exmem_rd, memwb_rd;
  logic             ifid_use_rs, ifid_use_rt, is_branch, branch_taken;
  logic             idex_regwrite, idex_memread, exmem_regwrite, exmem_memread, memwb_regwrite;
  logic             mem_busy, clr_cnt;

  logic        pc_write, ifid_load, pipe_hold, ifid_flush, idex_flush, fwd_br_a, fwd_br_b;
  logic [1:0]  forward_a, forward_b;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_write, s_ifid_load, s_pipe_hold, s_ifid_flush, s_idex_flush, s_fwd_br_a, s_fwd_br_b;
  logic [1:0]  s_forward_a, s_forward_b;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int checks = 0;
  int errors = 0;
  int es = 0;
  int ef = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_W(REG_W), .LOAD_LAT(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_use_rs(ifid_use_rs), .ifid_use_rt(ifid_use_rt),
    .is_branch(is_branch), .branch_taken(branch_taken),
    .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
    .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .exmem_memread(exmem_memread),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
    .mem_busy(mem_busy), .clr_cnt(clr_cnt),
    .pc_write(pc_write), .ifid_load(ifid_load), .pipe_hold(pipe_hold),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .forward_a(forward_a), .forward_b(forward_b), .fwd_br_a(fwd_br_a), .fwd_br_b(fwd_br_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(.REG_W(REG_W), .LOAD_LAT(3), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_use_rs(ifid_use_rs), .ifid_use_rt(ifid_use_rt),
    .is_branch(is_branch), .branch_taken(branch_taken),
    .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
    .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .exmem_memread(exmem_memread),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
    .mem_busy(mem_busy), .clr_cnt(clr_cnt),
    .pc_write(s_pc_write), .ifid_load(s_ifid_load), .pipe_hold(s_pipe_hold),
    .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
    .forward_a(s_forward_a), .forward_b(s_forward_b), .fwd_br_a(s_fwd_br_a), .fwd_br_b(s_fwd_br_b),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ifid_rs = '0; ifid_rt = '0; ifid_use_rs = 1'b0; ifid_use_rt = 1'b0;
    is_branch = 1'b0; branch_taken = 1'b0;
    idex_rs = '0; idex_rt = '0; idex_rd = '0; idex_regwrite = 1'b0; idex_memread = 1'b0;
    exmem_rd = '0; exmem_regwrite = 1'b0; exmem_memread = 1'b0;
    memwb_rd = '0; memwb_regwrite = 1'b0;
    mem_busy = 1'b0; clr_cnt = 1'b0;
  endtask

  // Advance one clock; new inputs are applied 1 time unit after the edge, checks 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Stall/bubble outputs expected while a load-use or branch hazard holds the front end.
  task automatic chk_bubble(input string tag);
    chk({tag, "_pc_write"}, 16'(pc_write), 16'd0);
    chk({tag, "_ifid_load"}, 16'(ifid_load), 16'd0);
    chk({tag, "_idex_flush"}, 16'(idex_flush), 16'd1);
    chk({tag, "_ifid_flush"}, 16'(ifid_flush), 16'd0);
    chk({tag, "_pipe_hold"}, 16'(pipe_hold), 16'd0);
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    idex_rs = 5'd3; exmem_rd = 5'd3; exmem_regwrite = 1'b1;
    ifid_rs = 5'd3; is_branch = 1'b1;
    #2;
    chk("rst_pc_write", 16'(pc_write), 16'd0);
    chk("rst_ifid_load", 16'(ifid_load), 16'd0);
    chk("rst_pipe_hold", 16'(pipe_hold), 16'd1);
    chk("rst_forward_a", 16'(forward_a), 16'd0);
    chk("rst_fwd_br_a", 16'(fwd_br_a), 16'd0);
    tick(); tick();
    chk("rst_stall_cnt", stall_cnt, 16'd0);
    chk("rst_flush_cnt", flush_cnt, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    tick();

    // Test 1: ALU forwarding priority and register-0 exclusion.
    idex_rs = 5'd3; exmem_rd = 5'd3; exmem_regwrite = 1'b1; memwb_rd = 5'd3; memwb_regwrite = 1'b1;
    settle();
    chk("t1_fwd_a_exmem", 16'(forward_a), 16'd2);
    chk("t1_pc_write", 16'(pc_write), 16'd1);
    chk("t1_ifid_load", 16'(ifid_load), 16'd1);
    chk("t1_pipe_hold", 16'(pipe_hold), 16'd0);
    exmem_memread = 1'b1;
    settle();
    chk("t1_fwd_a_exmem_load", 16'(forward_a), 16'd1);
    exmem_regwrite = 1'b0; exmem_memread = 1'b0;
    settle();
    chk("t1_fwd_a_memwb", 16'(forward_a), 16'd1);
    idex_rt = 5'd7; memwb_rd = 5'd7;
    settle();
    chk("t1_fwd_b_memwb", 16'(forward_b), 16'd1);
    chk("t1_fwd_a_none", 16'(forward_a), 16'd0);
    idex_rs = '0; idex_rt = '0; exmem_rd = '0; memwb_rd = '0; exmem_regwrite = 1'b1;
    settle();
    chk("t1_fwd_a_r0", 16'(forward_a), 16'd0);
    chk("t1_fwd_b_r0", 16'(forward_b), 16'd0);
    clear_inputs();
    tick();

    // Test 2: LOAD_LAT=3 load-use, branch_taken ignored inside LSTALL.
    idex_memread = 1'b1; idex_rd = 5'd5; ifid_rs = 5'd5; ifid_use_rs = 1'b1;
    settle();
    chk_bubble("t2_c0");
    tick(); es++; ef++;
    branch_taken = 1'b1;
    settle();
    chk_bubble("t2_c1");
    tick(); es++; ef++;
    clear_inputs();
    settle();
    chk_bubble("t2_c2");
    tick(); es++; ef++;
    chk("t2_run_pc_write", 16'(pc_write), 16'd1);
    chk("t2_run_idex_flush", 16'(idex_flush), 16'd0);
    chk("t2_stall_cnt", stall_cnt, 16'(es));
    chk("t2_flush_cnt", flush_cnt, 16'(ef));

    // Test 3: mem_busy mid-LSTALL freezes the count.
    idex_memread = 1'b1; idex_rd = 5'd5; ifid_rt = 5'd5; ifid_use_rt = 1'b1;
    settle();
    chk_bubble("t3_c0");
    tick(); es++; ef++;
    clear_inputs();
    mem_busy = 1'b1;
    settle();
    chk("t3_busy_hold", 16'(pipe_hold), 16'd1);
    chk("t3_busy_pc_write", 16'(pc_write), 16'd0);
    chk("t3_busy_idex_flush", 16'(idex_flush), 16'd0);
    tick(); es++;
    settle();
    chk("t3_busy2_hold", 16'(pipe_hold), 16'd1);
    tick(); es++;
    mem_busy = 1'b0;
    settle();
    chk_bubble("t3_c3");
    tick(); es++; ef++;
    settle();
    chk_bubble("t3_c4");
    tick(); es++; ef++;
    chk("t3_run_pc_write", 16'(pc_write), 16'd1);
    chk("t3_stall_cnt", stall_cnt, 16'(es));
    chk("t3_flush_cnt", flush_cnt, 16'(ef));

    // Test 4: branch data hazard, branch forwarding, taken-branch flush.
    is_branch = 1'b1; ifid_rs = 5'd2; ifid_use_rs = 1'b1; idex_rd = 5'd2; idex_regwrite = 1'b1;
    ifid_use_rs = 1'b0;
    settle();
    chk("t4_nouse_pc_write", 16'(pc_write), 16'd1);
    ifid_use_rs = 1'b1;
    settle();
    chk_bubble("t4_br_idex");
    tick(); es++; ef++;
    idex_regwrite = 1'b0; idex_rd = '0;
    exmem_rd = 5'd2; exmem_regwrite = 1'b1; exmem_memread = 1'b1;
    settle();
    chk("t4_br_load_pc_write", 16'(pc_write), 16'd0);
    chk("t4_br_load_fwd", 16'(fwd_br_a), 16'd0);
    exmem_memread = 1'b0;
    settle();
    chk("t4_fwd_br_a", 16'(fwd_br_a), 16'd1);
    chk("t4_fwd_br_b", 16'(fwd_br_b), 16'd0);
    chk("t4_fwd_pc_write", 16'(pc_write), 16'd1);
    branch_taken = 1'b1;
    settle();
    chk("t4_taken_ifid_flush", 16'(ifid_flush), 16'd1);
    chk("t4_taken_idex_flush", 16'(idex_flush), 16'd0);
    chk("t4_taken_pc_write", 16'(pc_write), 16'd1);
    tick(); ef++;
    clear_inputs();
    settle();
    chk("t4_after_ifid_flush", 16'(ifid_flush), 16'd0);
    chk("t4_stall_cnt", stall_cnt, 16'(es));
    chk("t4_flush_cnt", flush_cnt, 16'(ef));

    // Test 5: load-use beats a taken branch.
    ifid_rt = 5'd4; ifid_use_rt = 1'b1; idex_memread = 1'b1; idex_rd = 5'd4; branch_taken = 1'b1;
    settle();
    chk_bubble("t5_c0");
    tick(); es++; ef++;
    clear_inputs();
    tick(); es++; ef++;
    tick(); es++; ef++;
    chk("t5_run_pc_write", 16'(pc_write), 16'd1);
    chk("t5_stall_cnt", stall_cnt, 16'(es));

    // Test 6: saturation of the 4-bit twin, then clear beating a stall.
    mem_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(); es++;
    end
    chk("t6_stall_cnt16", stall_cnt, 16'(es));
    chk("t6_stall_cnt4_sat", 16'(s_stall_cnt), 16'd15);
    chk("t6_flush_cnt4", 16'(s_flush_cnt), 16'(ef));
    mem_busy = 1'b0; branch_taken = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(); ef++;
    end
    chk("t6_flush_cnt16", flush_cnt, 16'(ef));
    chk("t6_flush_cnt4_sat", 16'(s_flush_cnt), 16'd15);
    branch_taken = 1'b0; mem_busy = 1'b1; clr_cnt = 1'b1;
    tick();
    chk("t6_clr_stall_cnt", stall_cnt, 16'd0);
    chk("t6_clr_flush_cnt", flush_cnt, 16'd0);
    chk("t6_clr_stall_cnt4", 16'(s_stall_cnt), 16'd0);
    chk("t6_clr_flush_cnt4", 16'(s_flush_cnt), 16'd0);
    clr_cnt = 1'b0;
    tick();
    chk("t6_post_clr_stall", stall_cnt, 16'd1);
    mem_busy = 1'b0;
    tick();
    chk("t6_idle_stall", stall_cnt, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

- Parametrised hazard, stall and forwarding controller for the 5-stage MIPS pipeline; successor to the combined hazard/forwarding logic in the CPU controller.
- Adds what that logic lacks:
  - configurable load latency (multi-cycle load-use stalls);
  - ID-stage branch operand forwarding and branch data hazard stalls;
  - global freeze on data-memory wait;
  - saturating stall/flush performance counters.
- Sits beside the main decoder; drives PC/IF-ID enables, flushes and ALU/branch forwarding muxes.

## Interface
Parameters:
- REG_W, 5, register address width
- LOAD_LAT, 1, cycles of bubble inserted per load-use hazard (1..15)
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- ifid_rs, ifid_rt  in  REG_W each  source registers of the instruction in ID
- ifid_use_rs, ifid_use_rt  in  1 each  ID instruction actually reads rs / rt
- is_branch  in  1  ID instruction is a conditional branch (compares in ID)
- branch_taken  in  1  ID branch comparison result, taken
- idex_rs, idex_rt, idex_rd  in  REG_W each  ID/EX source and destination registers
- idex_regwrite, idex_memread  in  1 each
- exmem_rd  in  REG_W
- exmem_regwrite, exmem_memread  in  1 each
- memwb_rd  in  REG_W
- memwb_regwrite  in  1
- mem_busy  in  1  data memory not ready; freeze pipeline
- clr_cnt  in  1  synchronous clear of performance counters
- pc_write, ifid_load  out  1 each  enables
- pipe_hold  out  1  freeze ID/EX, EX/MEM, MEM/WB
- ifid_flush, idex_flush  out  1 each  insert bubble
- forward_a, forward_b  out  2 each  ALU operand source: 00 regfile, 01 MEM/WB, 10 EX/MEM
- fwd_br_a, fwd_br_b  out  1 each  branch comparator takes EX/MEM ALU result
- stall_cnt, flush_cnt  out  CNT_W each  performance counters

## Operation
- Register 0 never matches any hazard or forwarding condition.
- ALU forwarding (forward_a on idex_rs, forward_b on idex_rt):
  - 10 when exmem_regwrite, !exmem_memread and exmem_rd == src;
  - else 01 when memwb_regwrite and memwb_rd == src;
  - else 00.
- Branch forwarding: fwd_br_a is 1 when is_branch, exmem_regwrite, !exmem_memread and exmem_rd == ifid_rs. fwd_br_b is the same with ifid_rt.
- Dependency on a source: match on ifid_rs gated by ifid_use_rs; match on ifid_rt gated by ifid_use_rt.
- Hazard priority, highest first, evaluated each cycle in state RUN:
  1. mem_busy: pipe_hold=1, pc_write=0, ifid_load=0, no flushes.
  2. Load-use: idex_memread, idex_rd depended on by the ID instruction.
     - pc_write=0, ifid_load=0, idex_flush=1.
     - If LOAD_LAT>1, go to LSTALL with count = LOAD_LAT-1.
  3. Branch data hazard: is_branch and either of:
     - idex_regwrite with idex_rd depended on;
     - exmem_memread with exmem_rd depended on.
     Response: pc_write=0, ifid_load=0, idex_flush=1 for this cycle only.
  4. branch_taken with no stall: ifid_flush=1, pc_write=1.
  5. Otherwise: pc_write=1, ifid_load=1, all flushes 0.
- FSM states:
  - RUN, evaluated as above.
  - LSTALL:
    - Outputs each cycle: pc_write=0, ifid_load=0, idex_flush=1.
    - count decrements per cycle; at count==1, next state is RUN.
    - mem_busy in LSTALL overrides outputs as in priority 1 and freezes count.
    - branch_taken is ignored in LSTALL.
- Counters:
  - stall_cnt +1 every cycle pc_write==0.
  - flush_cnt +1 every cycle ifid_flush or idex_flush is 1; a cycle with both counts once.
  - Both saturate at all-ones. clr_cnt zeroes both and has priority over increment.

## Timing
- All control and forwarding outputs are combinational from current state and inputs, with no added latency.
- State, count and counters update on rising clk.
- Reset, asynchronous while rst=0:
  - state RUN, count 0, stall_cnt=flush_cnt=0;
  - outputs forced pc_write=0, ifid_load=0, pipe_hold=1, flushes 0, forwards 00, fwd_br 0.
- Release of rst takes effect on the first rising edge after deassertion.
- A load-use hazard stalls for exactly LOAD_LAT cycles when mem_busy=0, plus one cycle per mem_busy cycle.
- Reset during LSTALL aborts the stall immediately.

## Test plan
- Test 1: ALU chain add $3 then sub using $3, with exmem_rd=3 and memwb_rd=3 both writing -> forward_a=10. Then memwb_rd=3 alone -> 01. rd=0 -> 00.
- Test 2: LOAD_LAT=3, lw $5 then add using $5 -> pc_write=0 and idex_flush=1 for exactly 3 cycles, stall_cnt +3, flush_cnt +3, then RUN.
- Test 3: LOAD_LAT=3, mem_busy=1 for 2 cycles mid-LSTALL -> pipe_hold=1 in those cycles, count frozen, 5 total stall cycles.
- Test 4: beq reading $2 while idex_rd=2 writing -> one-cycle bubble. Next cycle exmem_rd=2 (ALU result) -> fwd_br_a=1, no stall. branch_taken=1 -> ifid_flush=1 for one cycle.
- Test 5: branch_taken=1 together with a load-use hazard -> stall wins, ifid_flush=0.
- Test 6: counters preloaded near max (CNT_W=4) saturate at 15. clr_cnt=1 with a stall in the same cycle -> counters read 0.
